// File: rtl/scb_gen2.sv
// ============================================================================
//  Module      : scb_gen2
//  Description : In-order completion scoreboard. Up to two micro-ops per
//                cycle are inserted into a circular buffer of 2^W_ident
//                entries and tagged. Completion ports mark entries DONE by
//                tag, and the oldest entry retires once it is DONE (at most
//                one retire per cycle). A per-register busy vector reports
//                every destination register that still has a write in flight.
//
//  Ports       : clk, rst                 clock / async active-high reset
//                CDI_PC_v0/1, CDI_PD_uops0/1, CDI_PD_rd0/1
//                                         two-slot insert (slot 0 is older)
//                CDO_PC_ready             insert accepted this cycle
//                CDO_PC_tag0/1            tags assigned to slot 0 / slot 1
//                CDI_PC_done, CDI_PD_tag  N_CMP completion ports
//                CDO_PC_rtv, CDO_PC_rd, CDO_PC_selwb
//                                         registered retire outputs
//                CDO_PC_busy              pending-write vector per register
//                CFI_PC_clear             synchronous flush
//
//  Config      : `define SCB_BYPASS_EN lets a completion on the head entry
//                retire on the same edge that samples the completion.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scb_gen2 #(
  parameter int                   W_PA_REG    = 5,
  parameter int                   W_PD_UOPS   = 6,
  parameter int                   W_PC_SEL_WB = 2,
  parameter int                   W_ident     = 3,
  parameter int                   N_CMP       = 2,
  parameter logic [W_PD_UOPS-1:0] unused_op   = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       CDI_PC_v0,
  input  logic                       CDI_PC_v1,
  input  logic [W_PD_UOPS-1:0]       CDI_PD_uops0,
  input  logic [W_PD_UOPS-1:0]       CDI_PD_uops1,
  input  logic [W_PA_REG-1:0]        CDI_PD_rd0,
  input  logic [W_PA_REG-1:0]        CDI_PD_rd1,
  output logic                       CDO_PC_ready,
  output logic [W_ident-1:0]         CDO_PC_tag0,
  output logic [W_ident-1:0]         CDO_PC_tag1,
  input  logic [N_CMP-1:0]           CDI_PC_done,
  input  logic [N_CMP*W_ident-1:0]   CDI_PD_tag,
  output logic                       CDO_PC_rtv,
  output logic [W_PA_REG-1:0]        CDO_PC_rd,
  output logic [W_PC_SEL_WB-1:0]     CDO_PC_selwb,
  output logic [(1<<W_PA_REG)-1:0]   CDO_PC_busy,
  input  logic                       CFI_PC_clear
);

  localparam int DEPTH = 1 << W_ident;
  localparam int NREG  = 1 << W_PA_REG;
  // Two free entries are required so a full pair can always be accepted.
  localparam logic [W_ident:0] INS_LIMIT = (W_ident+1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    ENT_IDLE = 2'd0,
    ENT_PEND = 2'd1,
    ENT_DONE = 2'd2
  } ent_state_t;

  ent_state_t                 ent_state [DEPTH];
  logic [W_PA_REG-1:0]        ent_rd    [DEPTH];
  // Only the writeback-select slice of the micro-op is consumed downstream,
  // so that is the part of the uop kept per entry.
  logic [W_PC_SEL_WB-1:0]     ent_sel   [DEPTH];

  logic [W_ident-1:0]         head;
  logic [W_ident-1:0]         tail;
  logic [W_ident:0]           count;

  logic                       ins0;
  logic                       ins1;
  logic [1:0]                 ins_cnt;
  logic [W_ident-1:0]         tail_plus1;
  logic [W_ident-1:0]         slot1_idx;
  logic [DEPTH-1:0]           comp_hit;
  logic                       retire;
  logic [NREG-1:0]            busy_vec;

  // --------------------------------------------------------------------------
  // Insert decode
  // --------------------------------------------------------------------------
  assign CDO_PC_ready = (count <= INS_LIMIT);

  assign ins0 = CDI_PC_v0 && CDO_PC_ready && (CDI_PD_uops0 != unused_op);
  assign ins1 = CDI_PC_v1 && CDO_PC_ready && (CDI_PD_uops1 != unused_op);

  assign ins_cnt    = {1'b0, ins0} + {1'b0, ins1};
  assign tail_plus1 = tail + W_ident'(1);
  // Slot 1 lands right after slot 0 only if slot 0 actually took an entry.
  assign slot1_idx  = ins0 ? tail_plus1 : tail;

  assign CDO_PC_tag0 = tail;
  assign CDO_PC_tag1 = slot1_idx;

  // --------------------------------------------------------------------------
  // Completion decode: OR across ports so duplicate tags act only once.
  // --------------------------------------------------------------------------
  always_comb begin
    comp_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < N_CMP; p++) begin
        if (CDI_PC_done[p] && (CDI_PD_tag[p*W_ident +: W_ident] == W_ident'(e))) begin
          comp_hit[e] = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Retire decision (head only, in order)
  // --------------------------------------------------------------------------
`ifdef SCB_BYPASS_EN
  assign retire = (ent_state[head] == ENT_DONE) ||
                  ((ent_state[head] == ENT_PEND) && comp_hit[head]);
`else
  assign retire = (ent_state[head] == ENT_DONE);
`endif

  // --------------------------------------------------------------------------
  // Busy vector: every occupied entry flags its destination; r0 never busy.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_vec = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_state[e] != ENT_IDLE) begin
        busy_vec[ent_rd[e]] = 1'b1;
      end
    end
    busy_vec[0] = 1'b0;
  end

  assign CDO_PC_busy = busy_vec;

  // --------------------------------------------------------------------------
  // State update.
  // Retire targets the head and inserts target tail/tail+1; while inserting,
  // count <= DEPTH-2 so these indices never coincide. A completion on an
  // entry being inserted sees it IDLE and is dropped; the later insert
  // assignment sets it PEND. In bypass mode the retire assignment follows
  // the completion one, so the head ends IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        ent_state[e] <= ENT_IDLE;
        ent_rd[e]    <= '0;
        ent_sel[e]   <= '0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      CDO_PC_rtv   <= 1'b0;
      CDO_PC_rd    <= '0;
      CDO_PC_selwb <= '0;
    end else if (CFI_PC_clear) begin
      // Flush wins over everything else this cycle; rd/selwb hold.
      for (int e = 0; e < DEPTH; e++) begin
        ent_state[e] <= ENT_IDLE;
      end
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      CDO_PC_rtv <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (comp_hit[e] && (ent_state[e] == ENT_PEND)) begin
          ent_state[e] <= ENT_DONE;
        end
      end

      if (retire) begin
        ent_state[head] <= ENT_IDLE;
        head            <= head + W_ident'(1);
        CDO_PC_rtv      <= 1'b1;
        CDO_PC_rd       <= ent_rd[head];
        CDO_PC_selwb    <= (ent_rd[head] == '0) ? '0 : ent_sel[head];
      end else begin
        CDO_PC_rtv <= 1'b0;
      end

      if (ins0) begin
        ent_state[tail] <= ENT_PEND;
        ent_rd[tail]    <= CDI_PD_rd0;
        ent_sel[tail]   <= CDI_PD_uops0[W_PC_SEL_WB-1:0];
      end
      if (ins1) begin
        ent_state[slot1_idx] <= ENT_PEND;
        ent_rd[slot1_idx]    <= CDI_PD_rd1;
        ent_sel[slot1_idx]   <= CDI_PD_uops1[W_PC_SEL_WB-1:0];
      end

      tail  <= tail + W_ident'(ins_cnt);
      count <= count + (W_ident+1)'(ins_cnt) - (W_ident+1)'(retire);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scb_gen2.sv
// ============================================================================
//  Module      : tb_scb_gen2
//  Description : Self-checking bench for scb_gen2. A queue of in-flight
//                micro-ops (oldest first) serves as the reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scb_gen2;

  localparam int              W_RD   = 5;
  localparam int              W_UOP  = 6;
  localparam int              W_SEL  = 2;
  localparam int              W_TAG  = 3;
  localparam int              NCMP   = 2;
  localparam int              DEPTH  = 8;
  localparam logic [W_UOP-1:0] UNUSED = 6'h3f;

  logic                  clk;
  logic                  rst;
  logic                  v0, v1;
  logic [W_UOP-1:0]      uops0, uops1;
  logic [W_RD-1:0]       rd0, rd1;
  logic                  ready;
  logic [W_TAG-1:0]      tag0, tag1;
  logic [NCMP-1:0]       done;
  logic [NCMP*W_TAG-1:0] ctag;
  logic                  rtv;
  logic [W_RD-1:0]       rd_o;
  logic [W_SEL-1:0]      selwb;
  logic [31:0]           busy;
  logic                  clear;

  scb_gen2 #(
    .W_PA_REG    (W_RD),
    .W_PD_UOPS   (W_UOP),
    .W_PC_SEL_WB (W_SEL),
    .W_ident     (W_TAG),
    .N_CMP       (NCMP),
    .unused_op   (UNUSED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .CDI_PC_v0    (v0),
    .CDI_PC_v1    (v1),
    .CDI_PD_uops0 (uops0),
    .CDI_PD_uops1 (uops1),
    .CDI_PD_rd0   (rd0),
    .CDI_PD_rd1   (rd1),
    .CDO_PC_ready (ready),
    .CDO_PC_tag0  (tag0),
    .CDO_PC_tag1  (tag1),
    .CDI_PC_done  (done),
    .CDI_PD_tag   (ctag),
    .CDO_PC_rtv   (rtv),
    .CDO_PC_rd    (rd_o),
    .CDO_PC_selwb (selwb),
    .CDO_PC_busy  (busy),
    .CFI_PC_clear (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int         tag;
    logic [4:0] rd;
    logic [5:0] uop;
    bit         done;
  } ent_t;

  ent_t       q[$];
  int         mtail;
  logic       m_rtv;
  logic [4:0] m_rd;
  logic [1:0] m_sel;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    mtail = 0;
    m_rtv = 1'b0;
    m_rd  = '0;
    m_sel = '0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, advance the model, then check registered outputs after the edge.
  task automatic step(input logic a0, input logic [5:0] u0, input logic [4:0] r0,
                      input logic a1, input logic [5:0] u1, input logic [4:0] r1,
                      input logic [1:0] dn, input logic [5:0] tg, input logic clr);
    bit          rdy, i0, i1, head_done_old, head_hit, ret;
    logic [31:0] eb;
    v0 = a0; uops0 = u0; rd0 = r0;
    v1 = a1; uops1 = u1; rd1 = r1;
    done = dn; ctag = tg; clear = clr;
    #1;
    rdy = (DEPTH - q.size()) >= 2;
    i0  = a0 && rdy && (u0 != UNUSED);
    i1  = a1 && rdy && (u1 != UNUSED);
    eb  = '0;
    foreach (q[k]) if (q[k].rd != 0) eb[q[k].rd] = 1'b1;
    chk("ready", ready, rdy);
    chk("tag0", tag0, mtail);
    chk("tag1", tag1, (mtail + (i0 ? 1 : 0)) % DEPTH);
    chk("busy", busy, eb);

    if (clr) begin
      q.delete();
      mtail = 0;
      m_rtv = 1'b0;
    end else begin
      head_done_old = (q.size() > 0) && q[0].done;
      head_hit      = 1'b0;
      for (int p = 0; p < NCMP; p++) begin
        if (dn[p]) begin
          foreach (q[k]) begin
            if (q[k].tag == int'(tg[p*3 +: 3])) begin
              if (k == 0 && !q[k].done) head_hit = 1'b1;
              q[k].done = 1'b1;
            end
          end
        end
      end
      ret = head_done_old;
`ifdef SCB_BYPASS_EN
      ret = ret || head_hit;
`endif
      if (ret) begin
        m_rtv = 1'b1;
        m_rd  = q[0].rd;
        m_sel = (q[0].rd == 0) ? 2'b00 : q[0].uop[1:0];
        void'(q.pop_front());
      end else begin
        m_rtv = 1'b0;
      end
      if (i0) begin
        q.push_back('{tag: mtail, rd: r0, uop: u0, done: 1'b0});
        mtail = (mtail + 1) % DEPTH;
      end
      if (i1) begin
        q.push_back('{tag: mtail, rd: r1, uop: u1, done: 1'b0});
        mtail = (mtail + 1) % DEPTH;
      end
    end

    @(posedge clk);
    #1;
    chk("rtv", rtv, m_rtv);
    chk("rd", rd_o, m_rd);
    chk("selwb", selwb, m_sel);
    chk("count", dut.count, q.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 2'b00, 6'h00, 0);
  endtask

  // Complete the two oldest in-flight entries (if any).
  task automatic complete_oldest();
    logic [1:0] dn;
    logic [5:0] tg;
    dn = 2'b00;
    tg = 6'h00;
    if (q.size() > 0) begin dn[0] = 1'b1; tg[2:0] = 3'(q[0].tag); end
    if (q.size() > 1) begin dn[1] = 1'b1; tg[5:3] = 3'(q[1].tag); end
    step(0, 0, 0, 0, 0, 0, dn, tg, 0);
  endtask

  initial begin
    logic [1:0] dn;
    logic [5:0] tg;
    logic [5:0] ua, ub;

    rst = 1'b1;
    v0 = 0; v1 = 0; uops0 = 0; uops1 = 0; rd0 = 0; rd1 = 0;
    done = 0; ctag = 0; clear = 0;
    model_reset();
    #11;
    chk("rst_rtv", rtv, 1'b0);
    chk("rst_rd", rd_o, 5'd0);
    chk("rst_selwb", selwb, 2'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_tag0", tag0, 3'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_noretire", rtv, 1'b0);

    // Pair insert rd 5 / rd 7, then complete out of order.
    step(1, 6'h01, 5'd5, 1, 6'h02, 5'd7, 2'b00, 6'h00, 0);
    step(0, 0, 0, 0, 0, 0, 2'b01, {3'd0, 3'd1}, 0);
    step(0, 0, 0, 0, 0, 0, 2'b01, {3'd0, 3'd0}, 0);
    idle(3);

    // Fill to seven, attempt inserts while not ready, then drain with wrap.
    step(1, 6'h05, 5'd3, 0, 0, 0, 2'b00, 6'h00, 0);
    for (int i = 0; i < 4; i++)
      step(1, 6'(i + 8), 5'(i + 10), 1, 6'(i + 16), 5'(i + 20), 2'b00, 6'h00, 0);
    step(1, 6'h09, 5'd30, 1, 6'h0a, 5'd31, 2'b00, 6'h00, 0);
    complete_oldest();
    idle(1);
    step(1, 6'h0b, 5'd1, 1, 6'h0c, 5'd2, 2'b00, 6'h00, 0);
    for (int i = 0; i < 6; i++) complete_oldest();
    idle(3);

    // rd 0 in slot 0 and a no-op in slot 1.
    step(1, 6'h07, 5'd0, 1, UNUSED, 5'd9, 2'b00, 6'h00, 0);
    complete_oldest();
    idle(2);

    // Flush with same-cycle insert and completion.
    step(1, 6'h03, 5'd12, 1, 6'h06, 5'd13, 2'b00, 6'h00, 0);
    complete_oldest();
    step(1, 6'h01, 5'd14, 1, 6'h02, 5'd15, 2'b01, {3'd0, 3'(q[0].tag)}, 1);
    idle(1);

    // Single-entry completion-to-retire latency.
    step(1, 6'h0e, 5'd17, 0, 0, 0, 2'b00, 6'h00, 0);
    step(0, 0, 0, 0, 0, 0, 2'b01, {3'd0, 3'(q[0].tag)}, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      dn = 2'b00;
      tg = 6'h00;
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(1, 0) == 1) begin
          dn[p] = 1'b1;
          if (q.size() > 0 && $urandom_range(3, 0) != 0)
            tg[p*3 +: 3] = 3'(q[$urandom_range(q.size() - 1, 0)].tag);
          else
            tg[p*3 +: 3] = 3'($urandom_range(7, 0));
        end
      end
      ua = ($urandom_range(7, 0) == 0) ? UNUSED : 6'($urandom_range(62, 0));
      ub = ($urandom_range(7, 0) == 0) ? UNUSED : 6'($urandom_range(62, 0));
      step(1'($urandom_range(1, 0)), ua, 5'($urandom_range(31, 0)),
           1'($urandom_range(1, 0)), ub, 5'($urandom_range(31, 0)),
           dn, tg, ($urandom_range(39, 0) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    step(1, 6'h11, 5'd18, 1, 6'h12, 5'd19, 2'b00, 6'h00, 0);
    complete_oldest();
    v0 = 0; v1 = 0; done = 0; clear = 0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rtv", rtv, 1'b0);
    chk("arst_rd", rd_o, 5'd0);
    chk("arst_selwb", selwb, 2'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_ready", ready, 1'b1);
    chk("arst_count", dut.count, 4'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scb_gen2.md
SCB_GEN2 -- requirements
Module: scb_gen2

Interface
REQ-001 SHALL have parameter W_PA_REG, default 5, register address width.
REQ-002 SHALL have parameter W_PD_UOPS, default 6, micro-op width.
REQ-003 SHALL have parameter W_PC_SEL_WB, default 2, writeback select width.
REQ-004 SHALL have parameter W_ident, default 3, tag width; DEPTH = 2^W_ident entries, W_ident >= 2.
REQ-005 SHALL have parameter N_CMP, default 2, number of completion ports.
REQ-006 SHALL have parameter unused_op, default all-ones W_PD_UOPS, no-op encoding.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 CDI_PC_v0 / CDI_PC_v1  in  1 each  insert-valid, slot 0 older than slot 1.
REQ-010 CDI_PD_uops0 / CDI_PD_uops1  in  W_PD_UOPS each  micro-op per slot.
REQ-011 CDI_PD_rd0 / CDI_PD_rd1  in  W_PA_REG each  destination register per slot.
REQ-012 CDO_PC_ready  out  1  insert accepted this cycle.
REQ-013 CDO_PC_tag0 / CDO_PC_tag1  out  W_ident each  tag assigned to slot 0 / slot 1.
REQ-014 CDI_PC_done  in  N_CMP  per-port completion valid.
REQ-015 CDI_PD_tag  in  N_CMP*W_ident  per-port completion tag, port i at bits [i*W_ident +: W_ident].
REQ-016 CDO_PC_rtv  out  1  retire valid.
REQ-017 CDO_PC_rd / CDO_PC_selwb  out  W_PA_REG / W_PC_SEL_WB  retired destination and writeback select.
REQ-018 CDO_PC_busy  out  2^W_PA_REG  per-register pending-write vector.
REQ-019 CFI_PC_clear  in  1  synchronous flush.

Function
REQ-020 SHALL hold DEPTH entries in a circular buffer with head, tail and count registers; entry state IDLE, PEND or DONE, plus rd and uop fields.
REQ-021 CDO_PC_ready SHALL be 1 iff DEPTH - count >= 2, from registered state only.
REQ-022 Slot k SHALL be inserted iff CDI_PC_vk=1, CDO_PC_ready=1, uopsk != unused_op; inserted entry goes to PEND.
REQ-023 CDO_PC_tag0 SHALL equal tail; CDO_PC_tag1 SHALL equal tail+1 if slot 0 inserts, else tail (modulo DEPTH); tail advances by inserted count.
REQ-024 A completion on a PEND entry SHALL set it DONE; a completion on an IDLE or DONE entry SHALL be ignored; duplicate tags on several ports SHALL act once.
REQ-025 At most one entry SHALL retire per cycle, the head, only when DONE; retire sets it IDLE and advances head.
REQ-026 CDO_PC_rtv, CDO_PC_rd, CDO_PC_selwb SHALL be registered; selwb = uop[W_PC_SEL_WB-1:0], forced 0 when rd = 0; rtv = 0 in non-retire cycles, rd/selwb hold.
REQ-027 Insert and retire in the same cycle SHALL both take effect; count updates by inserted minus retired.
REQ-028 CDO_PC_busy[r] SHALL be 1 iff some PEND or DONE entry has rd = r, r != 0; bit 0 always 0; combinational from registered entries.
REQ-029 Head and tail SHALL wrap from DEPTH-1 to 0.
REQ-030 CFI_PC_clear SHALL set all entries IDLE and head/tail/count/rtv to 0 at the next edge, overriding same-cycle insert, completion and retire.

Reset
REQ-031 rst SHALL immediately force all entries IDLE, head = tail = count = 0, CDO_PC_rtv = 0, CDO_PC_rd = 0, CDO_PC_selwb = 0.
REQ-032 After reset: CDO_PC_ready = 1, tags 0/1, CDO_PC_busy all 0.
REQ-033 rst asserted mid-operation SHALL discard all entries; no retire SHALL occur in the cycle following reset release.

Configuration
REQ-034 Macro SCB_BYPASS_EN SHALL select completion-to-retire bypass.
REQ-035 Without SCB_BYPASS_EN: completion sampled at edge t sets DONE; retire registered at edge t+1 (rtv visible after t+1).
REQ-036 With SCB_BYPASS_EN: completion on the head PEND entry sampled at edge t SHALL retire at edge t (rtv visible after t); other entries unchanged from REQ-035.

Verification
REQ-037 Reset, insert v0=1 rd0=5 v1=1 rd1=7 -> tag0=0 tag1=1, next cycle busy[5]=busy[7]=1, count=2.
REQ-038 Complete tag 1 then tag 0 -> retires in order rd=5 then rd=7, one per cycle, busy bits clear after each retire.
REQ-039 Insert pairs until count=7 -> ready=0 at count 7, inserts ignored, tail wraps 7->0 on later insert.
REQ-040 Insert rd0=0 and uops1=unused_op -> entry 0 retires with selwb=0, slot 1 not inserted, busy unchanged.
REQ-041 Clear asserted same cycle as insert and completion -> next cycle count=0, busy all 0, rtv=0, ready=1.
REQ-042 Single entry, complete at edge t -> rtv after edge t+1 without SCB_BYPASS_EN, after edge t with it.
